// File: rtl/uart_lite_pkg.sv
// uart_lite_pkg: register offsets, STAT/CTRL bit positions and AXI response code for uart_lite_regs.
package uart_lite_pkg;
    localparam logic [1:0] REG_RX   = 2'd0;
    localparam logic [1:0] REG_TX   = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;
    localparam int STAT_RX_VALID  = 0;
    localparam int STAT_RX_FULL   = 1;
    localparam int STAT_TX_EMPTY  = 2;
    localparam int STAT_TX_FULL   = 3;
    localparam int STAT_INTR_EN   = 4;
    localparam int STAT_OVERRUN   = 5;
    localparam int STAT_FRAME_ERR = 6;
    localparam int CTRL_RST_TX  = 0;
    localparam int CTRL_RST_RX  = 1;
    localparam int CTRL_INTR_EN = 4;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/uart_lite_regs_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; clr empties it and overrides push/pop in the same cycle.
module sync_fifo #(
    parameter int DATAW = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [DATAW-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [DATAW-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    logic [DATAW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign full = count == DEPTH_CNT;
    assign empty = count == '0;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign dout = mem[rptr];
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (rst && !clr && do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/uart_lite_regs.sv
// uart_lite_regs: AXI4-Lite UART-Lite register map over RX/TX FIFOs.
// Define UART_LITE_INTR_EN to add the intr pulse output.
module uart_lite_regs
    import uart_lite_pkg::*;
#(
    parameter int AXI_DATAW  = 32,
    parameter int AXI_ADDRW  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AXI_ADDRW-1:0]   awaddr,
    input  logic [2:0]             awprot,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [AXI_DATAW-1:0]   wdata,
    input  logic [AXI_DATAW/8-1:0] wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [AXI_ADDRW-1:0]   araddr,
    input  logic [2:0]             arprot,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [AXI_DATAW-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   rx_frame_err,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready
`ifdef UART_LITE_INTR_EN
    ,output logic                  intr
`endif
);
    logic run, aw_got, w_got, w_strb_q, intr_en, overrun, frame_err;
    logic [1:0] aw_sel_q, wsel, rsel;
    logic [7:0] w_data_q, wbyte, rd_byte, stat, rx_dout, tx_dout;
    logic aw_hs, w_hs, ar_hs, wstb, wr_fire, wr_en, ctrl_wr;
    logic tx_push, tx_clr, rx_clr, rx_pop, stat_rd, rx_drop;
    logic rx_full, rx_empty, tx_full, tx_empty;
    logic unused;
    assign unused = ^{awprot, arprot, wdata[AXI_DATAW-1:8], wstrb[AXI_DATAW/8-1:1], awaddr[1:0], araddr[1:0]};
    assign awready = run & ~aw_got;
    assign wready = run & ~w_got;
    assign arready = run & ~rvalid;
    assign bresp = AXI_RESP_OKAY;
    assign rresp = AXI_RESP_OKAY;
    assign aw_hs = awvalid & awready;
    assign w_hs = wvalid & wready;
    assign ar_hs = arvalid & arready;
    // AW and W may arrive in either order; use the latched copy once a channel has handshaken
    assign wsel = aw_got ? aw_sel_q : awaddr[3:2];
    assign wbyte = w_got ? w_data_q : wdata[7:0];
    assign wstb = w_got ? w_strb_q : wstrb[0];
    assign wr_fire = (aw_got | aw_hs) & (w_got | w_hs) & ~bvalid;
    assign wr_en = wr_fire & wstb;
    assign tx_push = wr_en & (wsel == REG_TX);
    assign ctrl_wr = wr_en & (wsel == REG_CTRL);
    assign tx_clr = ctrl_wr & wbyte[CTRL_RST_TX];
    assign rx_clr = ctrl_wr & wbyte[CTRL_RST_RX];
    assign rsel = araddr[3:2];
    assign rx_pop = ar_hs & (rsel == REG_RX);
    assign stat_rd = ar_hs & (rsel == REG_STAT);
    assign rx_drop = rx_valid & rx_full & ~rx_clr;
    assign stat = {1'b0, frame_err, overrun, intr_en, tx_full, tx_empty, rx_full, ~rx_empty};
    assign rd_byte = (rsel == REG_RX) ? (rx_empty ? 8'h00 : rx_dout) : (rsel == REG_STAT) ? stat : 8'h00;
    assign tx_valid = ~tx_empty;
    assign tx_data = tx_empty ? 8'h00 : tx_dout;
    sync_fifo #(.DATAW(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_valid), .pop(rx_pop), .clr(rx_clr),
        .din(rx_data), .full(rx_full), .empty(rx_empty), .dout(rx_dout)
    );
    sync_fifo #(.DATAW(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_valid & tx_ready), .clr(tx_clr),
        .din(wbyte), .full(tx_full), .empty(tx_empty), .dout(tx_dout)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            run <= 1'b0;
            aw_got <= 1'b0;
            w_got <= 1'b0;
            aw_sel_q <= '0;
            w_data_q <= '0;
            w_strb_q <= 1'b0;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            rdata <= '0;
            intr_en <= 1'b0;
            overrun <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            run <= 1'b1;
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_sel_q <= awaddr[3:2];
            end
            if (w_hs) begin
                w_got <= 1'b1;
                w_data_q <= wdata[7:0];
                w_strb_q <= wstrb[0];
            end
            if (wr_fire) bvalid <= 1'b1;
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                aw_got <= 1'b0;
                w_got <= 1'b0;
            end
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata <= AXI_DATAW'(rd_byte);
            end else if (rready) rvalid <= 1'b0;
            if (ctrl_wr) intr_en <= wbyte[CTRL_INTR_EN];
            overrun <= rx_drop | (overrun & ~stat_rd);
            frame_err <= (rx_valid & rx_frame_err) | (frame_err & ~stat_rd);
        end
    end
`ifdef UART_LITE_INTR_EN
    logic rx_empty_q, tx_empty_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            intr <= 1'b0;
            rx_empty_q <= 1'b1;
            tx_empty_q <= 1'b1;
        end else begin
            rx_empty_q <= rx_empty;
            tx_empty_q <= tx_empty;
            intr <= intr_en & ((rx_empty_q & ~rx_empty) | (~tx_empty_q & tx_empty));
        end
    end
`endif
endmodule

// File: tb/tb_uart_lite_regs.sv
// tb_uart_lite_regs: directed stimulus with queue scoreboard for read data, write responses and TX bytes.
module tb_uart_lite_regs;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;
    logic [3:0] awaddr = '0, araddr = '0;
    logic [2:0] awprot = '0, arprot = '0;
    logic awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
    logic [31:0] wdata = '0, rdata;
    logic [3:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid, tx_valid;
    logic [1:0] bresp, rresp;
    logic [7:0] rx_data = '0, tx_data;
    logic rx_valid = 0, rx_frame_err = 0, tx_ready = 0;
`ifdef UART_LITE_INTR_EN
    logic intr;
`endif
    int errors = 0, checks = 0;
    logic [31:0] rq[$];
    logic [1:0] bq[$];
    logic [7:0] txq[$];

    uart_lite_regs dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef UART_LITE_INTR_EN
        ,.intr(intr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid && rready) begin
            if (rq.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
            else begin
                chk("rdata", rdata, rq.pop_front());
                chk("rresp", 32'(rresp), 32'd0);
            end
        end
        if (bvalid && bready) begin
            if (bq.size() == 0) chk("unexpected_bvalid", 32'd1, 32'd0);
            else chk("bresp", 32'(bresp), 32'(bq.pop_front()));
        end
        if (tx_valid && tx_ready) begin
            if (txq.size() == 0) chk("unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
            else chk("tx_data", 32'(tx_data), 32'(txq.pop_front()));
        end
    end

    task automatic rx_byte(input logic [7:0] d, input logic fe);
        rx_data = d;
        rx_frame_err = fe;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_frame_err = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [7:0] exp);
        logic hs, got;
        rq.push_back({24'h0, exp});
        araddr = a;
        arvalid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); got = rvalid;
            @(posedge clk); #1;
        end
        if (!hs || !got) chk("read_timeout", 32'(a), 32'hFFFF_FFFF);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [7:0] d, input int lead, input int bdelay, input logic strobe_rx);
        logic aw_done, w_done, b_done;
        int c, bl;
        bq.push_back(2'b00);
        awaddr = a;
        awvalid = 1'b1;
        wdata = {24'h0, d};
        wstrb = 4'h1;
        wvalid = (lead == 0);
        bready = (bdelay == 0);
        if (strobe_rx) begin
            rx_data = 8'h99;
            rx_valid = 1'b1;
        end
        aw_done = 0; w_done = 0; b_done = 0; c = 0; bl = 0;
        while (!b_done && c < 40) begin
            @(negedge clk);
            if (aw_done && w_done && !b_done) chk("bvalid_held", 32'(bvalid), 32'd1);
            if (aw_done && (lead > 0 || bdelay > 0)) chk("no_second_aw", 32'(awready), 32'd0);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            if (bvalid && bready) b_done = 1;
            if (bvalid && !bready) bl++;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            c++;
            if (c == lead && !w_done) wvalid = 1'b1;
            if (bl >= bdelay) bready = 1'b1;
        end
        if (!b_done) chk("write_timeout", 32'(a), 32'hFFFF_FFFF);
        awvalid = 1'b0;
        wvalid = 1'b0;
        bready = 1'b1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, tx_valid, rdata[7:0], tx_data}, 32'h0);
`ifdef UART_LITE_INTR_EN
        chk("reset_intr", 32'(intr), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", 32'({awready, wready, arready}), 32'd0);
        @(negedge clk);
        chk("ready_after_reset", 32'({awready, wready, arready}), 32'd7);
        @(posedge clk); #1;

        rx_byte(8'h41, 0); rx_byte(8'h42, 0); rx_byte(8'h43, 0);
        axi_read(4'h8, 8'h05);
        axi_read(4'h4, 8'h00);
        axi_read(4'hC, 8'h00);
        axi_write(4'h8, 8'hFF, 0, 0, 0);
        axi_read(4'h8, 8'h05);
        axi_read(4'h0, 8'h41); axi_read(4'h0, 8'h42); axi_read(4'h0, 8'h43);
        axi_read(4'h0, 8'h00);
        axi_read(4'h8, 8'h04);

        for (int i = 0; i < 17; i++) rx_byte(8'(i), 0);
        axi_read(4'h8, 8'h27);
        axi_read(4'h8, 8'h07);
        for (int i = 0; i < 11; i++) axi_read(4'h0, 8'(i));
        axi_write(4'hC, 8'h02, 0, 0, 1);
        axi_read(4'h8, 8'h04);
        for (int i = 0; i < 16; i++) rx_byte(8'(8'h20 + i), 0);
        axi_read(4'h8, 8'h07);
        axi_write(4'hC, 8'h02, 0, 0, 1);
        axi_read(4'h8, 8'h04);

        tx_ready = 1'b0;
        axi_write(4'h4, 8'h55, 0, 0, 0);
        @(negedge clk);
        chk("tx_valid_hold", 32'(tx_valid), 32'd1);
        chk("tx_data_hold", 32'(tx_data), 32'h55);
        @(posedge clk); #1;
        axi_read(4'h8, 8'h00);
        txq.push_back(8'h55);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk);
        chk("tx_valid_drained", 32'(tx_valid), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            axi_write(4'h4, 8'(8'hA0 + i), 0, 0, 0);
            if (i < 16) txq.push_back(8'(8'hA0 + i));
        end
        axi_read(4'h8, 8'h08);
        tx_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 tx_ready = 1'b0;
        chk("tx_queue_drained", 32'(txq.size()), 32'd0);
        axi_read(4'h8, 8'h04);

        axi_write(4'hC, 8'h10, 3, 4, 0);
        axi_read(4'h8, 8'h14);

        rx_byte(8'h5A, 1);
`ifdef UART_LITE_INTR_EN
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n += int'(intr);
        end
        @(posedge clk); #1;
        chk("intr_pulse", 32'(n), 32'd1);
`else
        n = 0;
`endif
        axi_read(4'h8, 8'h55);
        axi_read(4'h8, 8'h15);
        axi_read(4'h0, 8'h5A);
        axi_read(4'h8, 8'h14);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 32'(rq.size() + bq.size() + txq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
